addsub_rr_scheduler: RTL
========================

// Module: addsub_rr_scheduler
// PURPOSE
//  Shares one combinational 64-bit adder-subtractor datapath among NUM_REQ requesters.
//  Round-robin arbitration over valid/ready request channels; one operation in flight at a time.
//  The block drives the datapath operands, captures its result and returns it on a per-requester response channel.
//  Sits between client engines and the single adder_subtractor instance at subsystem top.
// PARAMETERS
//  NUM_REQ  4   number of requesters, 2..16
//  WIDTH    64  operand/result width; must equal the datapath width
// PORTS
//  clk             in   1                 single clock, rising edge
//  rst             in   1                 synchronous, active-high reset
//  req_valid       in   NUM_REQ           per-requester request valid
//  req_ready       out  NUM_REQ           per-requester accept (at most one bit set)
//  req_op1         in   NUM_REQ x WIDTH   packed operand A per requester
//  req_op2         in   NUM_REQ x WIDTH   packed operand B per requester
//  req_mode        in   NUM_REQ           0 = add, 1 = subtract (op1 - op2)
//  au_op1          out  WIDTH             to datapath op1
//  au_op2          out  WIDTH             to datapath op2
//  au_mode         out  1                 to datapath mode
//  au_result       in   WIDTH             from datapath, combinational
//  au_carry_out    in   1                 from datapath, combinational
//  resp_valid      out  NUM_REQ           one-hot response valid
//  resp_ready      in   NUM_REQ           per-requester response accept
//  resp_result     out  WIDTH             shared response data
//  resp_carry      out  1                 captured carry_out
//  busy            out  1                 high whenever state != IDLE
// BEHAVIOUR
//  FSM states: IDLE -> EXEC -> RESP -> IDLE.
//  IDLE
//   - Grant g = first i with req_valid[i], scanning from rr_ptr upward with wrap (rr_ptr, .., NUM_REQ-1, 0, ..).
//   - req_ready[g] = 1, driven combinationally in IDLE only; all other req_ready bits 0.
//   - On handshake: latch op1, op2, mode and id = g; set rr_ptr = (g + 1) mod NUM_REQ; go to EXEC.
//  EXEC (one cycle)
//   - au_* are driven from the latched registers.
//   - At end of cycle, capture au_result and au_carry_out into response registers; go to RESP.
//  RESP
//   - resp_valid[id] = 1; hold resp_result and resp_carry stable.
//   - On resp_ready[id]: go to IDLE. A new grant is possible in that same IDLE cycle.
//   - resp_ready bits of other requesters are ignored.
//  Timing and throughput
//   - Latency: request accepted at cycle N; resp_valid at N+2; minimum 3 cycles per operation.
//   - req_valid dropped before its grant is legal; that requester is simply not selected.
//  Datapath outputs
//   - au_* hold their last latched value outside EXEC; they are 0 after reset.
//   - Arithmetic is modulo 2^WIDTH.
//   - resp_carry is passed through unmodified: for subtract, carry = 1 means no borrow.
//  Reset
//   - Every output is 0 after reset; rr_ptr = 0; state = IDLE.
//   - Reset in EXEC or RESP drops the in-flight operation; no response is issued for it.
// CONFIGURATION
//  ADDSUB_SCHED_OVERFLOW_EN
//   - Defined: adds output resp_ovf (1 bit), the signed overflow of the captured operation.
//     Add: sign(op1) == sign(op2) && sign(res) != sign(op1).
//     Sub: sign(op1) != sign(op2) && sign(res) != sign(op1).
//     Captured in EXEC with result; resets to 0.
//   - Undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  Package addsub_sched_pkg
//   - typedef enum logic {ADD = 1'b0, SUB = 1'b1} addsub_mode_e
//   - typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} sched_state_e
//   - typedef struct packed {op1, op2, mode} addsub_op_t, WIDTH-parametrised via package constant
//  Sub-module rr_picker #(N)
//   - Combinational: inputs req vector and ptr; outputs one-hot grant and binary index.
//   - Reused by other shared-resource schedulers.
// TESTING
//  1. Single request: req0 op1=5, op2=3, mode=0 -> resp_valid[0] at N+2, result=8, carry=0.
//  2. Subtract with borrow: op1=3, op2=5, mode=1 -> result=64'hFFFF_FFFF_FFFF_FFFE, carry=0.
//     With ADDSUB_SCHED_OVERFLOW_EN: ovf=0.
//  3. All 4 valid continuously -> grant order 0,1,2,3,0; no requester served twice before the others.
//  4. resp_ready[2] held low for 5 cycles -> resp stable, busy=1, no req_ready asserted.
//     Release -> next grant in the same IDLE cycle.
//  5. Reset asserted in RESP -> next cycle all outputs 0 and rr_ptr=0; the dropped op never responds.
//  6. Overflow (macro on): op1=64'h7FFF_FFFF_FFFF_FFFF, op2=1, add -> result=64'h8000_0000_0000_0000, ovf=1.

Source files
------------

// File: rtl/addsub_rr_scheduler_pkg.sv
// Shared types for the add/sub round-robin scheduler: operation record, FSM states, overflow helper.
// Pure declarations; no timing or flow control of its own.
package addsub_sched_pkg;

   localparam int DATA_W = 64;

   typedef enum logic {ADD = 1'b0, SUB = 1'b1} addsub_mode_e;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} sched_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      addsub_mode_e      mode;
   } addsub_op_t;

   // Signed overflow from operand and result sign bits.
   function automatic logic signed_ovf(addsub_mode_e mode, logic a, logic b, logic r);
      if (mode == ADD) return (a == b) && (r != a);
      else             return (a != b) && (r != a);
   endfunction

endpackage

// File: rtl/addsub_rr_scheduler_if.sv
// Request/response channels between client engines and the add/sub scheduler; resp_ovf exists only
// with ADDSUB_SCHED_OVERFLOW_EN. Valid/ready on both channels, response held until accepted.
interface addsub_rr_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 64
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_op1;
   logic [NUM_REQ*WIDTH-1:0] req_op2;
   logic [NUM_REQ-1:0]       req_mode;
   logic [NUM_REQ-1:0]       resp_valid;
   logic [NUM_REQ-1:0]       resp_ready;
   logic [WIDTH-1:0]         resp_result;
   logic                     resp_carry;
`ifdef ADDSUB_SCHED_OVERFLOW_EN
   logic                     resp_ovf;
`endif

   modport master (
`ifdef ADDSUB_SCHED_OVERFLOW_EN
      input  resp_ovf,
`endif
      input  req_ready, resp_valid, resp_result, resp_carry,
      output req_valid, req_op1, req_op2, req_mode, resp_ready
   );

   modport slave (
`ifdef ADDSUB_SCHED_OVERFLOW_EN
      output resp_ovf,
`endif
      input  req_valid, req_op1, req_op2, req_mode, resp_ready,
      output req_ready, resp_valid, resp_result, resp_carry
   );

endinterface

// File: rtl/addsub_rr_scheduler_rr_picker.sv
// Round-robin picker: first set bit of req scanning upward from ptr with wrap; one-hot grant and index.
// Purely combinational, zero latency; no backpressure (caller decides when a grant is taken).
module rr_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx
);
   localparam int IW = $clog2(N);

   logic found;
   int   j;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int off = 0; off < N; off++) begin
         j = (int'(ptr) + off) % N;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// Round-robin sharing of one combinational add/sub datapath; optional resp_ovf via ADDSUB_SCHED_OVERFLOW_EN.
// Accept at N, response valid at N+2 (>=3 cycles/op); no new grant while a response awaits resp_ready.
module addsub_rr_scheduler
   import addsub_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   addsub_rr_scheduler_if.slave bus,
   output logic [WIDTH-1:0]    au_op1,
   output logic [WIDTH-1:0]    au_op2,
   output logic                au_mode,
   input  logic [WIDTH-1:0]    au_result,
   input  logic                au_carry_out,
   output logic                busy
);
   localparam int IW = $clog2(NUM_REQ);

   sched_state_e       state, state_n;
   logic [IW-1:0]      rr_ptr, id_q, pick_idx;
   logic [NUM_REQ-1:0] pick_grant;
   logic               take;
   addsub_op_t         op_q;
   logic [WIDTH-1:0]   sel_op1, sel_op2;
   logic [WIDTH-1:0]   res_q;
   logic               carry_q;
`ifdef ADDSUB_SCHED_OVERFLOW_EN
   logic               ovf_q;
`endif

   rr_picker #(.N(NUM_REQ)) u_pick (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   always_comb begin
      sel_op1 = bus.req_op1[pick_idx*WIDTH +: WIDTH];
      sel_op2 = bus.req_op2[pick_idx*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n        = state;
      take           = 1'b0;
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      case (state)
         S_IDLE: begin
            bus.req_ready = pick_grant;
            if (|pick_grant) begin
               take    = 1'b1;
               state_n = S_EXEC;
            end
         end
         S_EXEC: state_n = S_RESP;
         S_RESP: begin
            bus.resp_valid[id_q] = 1'b1;
            if (bus.resp_ready[id_q]) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Operands stay latched after EXEC so the datapath inputs do not toggle between operations.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr  <= '0;
         id_q    <= '0;
         op_q    <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
`ifdef ADDSUB_SCHED_OVERFLOW_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         if (take) begin
            op_q.op1  <= sel_op1;
            op_q.op2  <= sel_op2;
            op_q.mode <= addsub_mode_e'(bus.req_mode[pick_idx]);
            id_q      <= pick_idx;
            rr_ptr    <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
         end
         if (state == S_EXEC) begin
            res_q   <= au_result;
            carry_q <= au_carry_out;
`ifdef ADDSUB_SCHED_OVERFLOW_EN
            ovf_q   <= signed_ovf(op_q.mode, op_q.op1[WIDTH-1], op_q.op2[WIDTH-1],
                                  au_result[WIDTH-1]);
`endif
         end
      end
   end

   assign au_op1          = op_q.op1;
   assign au_op2          = op_q.op2;
   assign au_mode         = op_q.mode;
   assign busy            = (state != S_IDLE);
   assign bus.resp_result = res_q;
   assign bus.resp_carry  = carry_q;
`ifdef ADDSUB_SCHED_OVERFLOW_EN
   assign bus.resp_ovf    = ovf_q;
`endif

endmodule
